// File: rtl/blink_pkg.sv
// Shared types and constants for the LED blink sequencer.
// Optional build macro used by blink_sequencer: BLINK_LOOP_EN.
package blink_pkg;

   localparam int TICK_W_DEF = 28;
   localparam int DEPTH_DEF  = 8;
   localparam int REP_W_DEF  = 4;

   // Tick counts for common durations on the 100 MHz board clock.
   localparam int MS_1 = 99_999;
   localparam int S_1  = 99_999_999;

   // One step of the blink pattern at the default field widths.
   typedef struct packed {
      logic [TICK_W_DEF-1:0] on;
      logic [TICK_W_DEF-1:0] off;
      logic [REP_W_DEF-1:0]  rep;
   } step_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2
   } state_t;

   // Requested sequence lengths beyond the table size run the whole table.
   function automatic int clamp_len(input int len, input int depth);
      return (len > depth) ? depth : len;
   endfunction

endpackage

// File: rtl/blink_sequencer_onoff_timer.sv
// Phase timer: counts 0..limit and flags the last cycle of the phase.
// The count restarts from zero after the expiring cycle or when load is held.
module onoff_timer #(
   parameter int TICK_W = 28
) (
   input  logic              CLK100MHZ,
   input  logic              CPU_RESETN,
   input  logic              load,
   input  logic [TICK_W-1:0] limit,
   output logic              expire
);

   logic [TICK_W-1:0] cnt_reg;
   logic [TICK_W-1:0] cnt_next;

   // The compare ends the phase at limit, so the counter can never wrap.
   assign expire = (cnt_reg == limit);

   // Clear on load or at the end of a phase, otherwise advance by one tick.
   always_comb begin
      cnt_next = cnt_reg + TICK_W'(1);
      if (load || expire) begin
         cnt_next = '0;
      end
   end

   // Tick counter register.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

endmodule

// File: rtl/blink_sequencer.sv
// LED pattern sequencer: walks a run-time loaded table of {on, off, rep}
// steps, driving one on/off timer. Build macro BLINK_LOOP_EN makes the run
// wrap to step 0 forever instead of finishing with a done pulse.
module blink_sequencer import blink_pkg::*; #(
   parameter int TICK_W = TICK_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int REP_W  = REP_W_DEF
) (
   input  logic                       CLK100MHZ,
   input  logic                       CPU_RESETN,
   input  logic                       cfg_we,
   input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
   input  logic [TICK_W-1:0]          cfg_on,
   input  logic [TICK_W-1:0]          cfg_off,
   input  logic [REP_W-1:0]           cfg_rep,
   output logic                       cfg_nak,
   input  logic [$clog2(DEPTH):0]     seq_len,
   input  logic                       start,
   input  logic                       stop,
   output logic                       LED,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(DEPTH)-1:0]   step_idx
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [TICK_W-1:0] on_tab  [DEPTH];
   logic [TICK_W-1:0] off_tab [DEPTH];
   logic [REP_W-1:0]  rep_tab [DEPTH];
   logic [DEPTH-1:0]  wr_sel;

   state_t            state_reg, state_next;
   logic [AW-1:0]     step_reg, step_next;
   logic [REP_W-1:0]  rep_reg, rep_next;
   logic [LW-1:0]     len_reg, len_next;
   logic              done_reg, done_next;
   logic              nak_reg, nak_next;
   logic              running;
   logic              wr_ok;
   logic              tmr_load;
   logic              tmr_expire;
   logic [TICK_W-1:0] tmr_limit;

   assign running = (state_reg != ST_IDLE);
   assign wr_ok   = cfg_we && !running;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
         assign wr_sel[gi] = wr_ok && (cfg_addr == AW'(gi));
      end
   endgenerate

   // Step table: written only while idle, cleared by reset.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         for (int i = 0; i < DEPTH; i++) begin
            on_tab[i]  <= '0;
            off_tab[i] <= '0;
            rep_tab[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) begin
               on_tab[i]  <= cfg_on;
               off_tab[i] <= cfg_off;
               rep_tab[i] <= cfg_rep;
            end
         end
      end
   end

   // Phase length comes straight from the table; it is frozen while running.
   assign tmr_limit = (state_reg == ST_ON) ? on_tab[step_reg] : off_tab[step_reg];

   onoff_timer #(.TICK_W(TICK_W)) u_timer (
      .CLK100MHZ  (CLK100MHZ),
      .CPU_RESETN (CPU_RESETN),
      .load       (tmr_load),
      .limit      (tmr_limit),
      .expire     (tmr_expire)
   );

   // Next-state logic: start/step/repeat sequencing, stop overrides all.
   always_comb begin
      state_next = state_reg;
      step_next  = step_reg;
      rep_next   = rep_reg;
      len_next   = len_reg;
      done_next  = 1'b0;
      nak_next   = cfg_we && running;
      tmr_load   = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            tmr_load = 1'b1;
            if (start && !stop) begin
               if (seq_len == '0) begin
                  done_next = 1'b1;
               end else begin
                  len_next   = LW'(clamp_len(int'(seq_len), DEPTH));
                  step_next  = '0;
                  // A write to entry 0 on the start edge must take effect now.
                  rep_next   = wr_sel[0] ? cfg_rep : rep_tab[0];
                  state_next = ST_ON;
               end
            end
         end
         ST_ON: begin
            if (tmr_expire) begin
               state_next = ST_OFF;
            end
         end
         ST_OFF: begin
            if (tmr_expire) begin
               if (rep_reg != '0) begin
                  rep_next   = rep_reg - REP_W'(1);
                  state_next = ST_ON;
               end else if (({1'b0, step_reg} + LW'(1)) < len_reg) begin
                  step_next  = step_reg + AW'(1);
                  rep_next   = rep_tab[step_reg + AW'(1)];
                  state_next = ST_ON;
               end else begin
`ifdef BLINK_LOOP_EN
                  step_next  = '0;
                  rep_next   = rep_tab[0];
                  state_next = ST_ON;
`else
                  state_next = ST_IDLE;
                  done_next  = 1'b1;
`endif
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      if (stop && running) begin
         state_next = ST_IDLE;
         step_next  = '0;
         done_next  = 1'b0;
         tmr_load   = 1'b1;
      end
   end

   // Sequencer state and status registers.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state_reg <= ST_IDLE;
         step_reg  <= '0;
         rep_reg   <= '0;
         len_reg   <= '0;
         done_reg  <= 1'b0;
         nak_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         step_reg  <= step_next;
         rep_reg   <= rep_next;
         len_reg   <= len_next;
         done_reg  <= done_next;
         nak_reg   <= nak_next;
      end
   end

   assign LED      = (state_reg == ST_ON);
   assign busy     = running;
   assign done     = done_reg;
   assign cfg_nak  = nak_reg;
   assign step_idx = step_reg;

endmodule

// File: tb/tb_blink_sequencer.sv
// Scoreboard bench for blink_sequencer: the driver expands each run into the
// expected per-cycle waveform from the step table; a monitor compares it.
module tb_blink_sequencer;
   import blink_pkg::*;

   localparam int DEPTH     = DEPTH_DEF;
   localparam int AW        = $clog2(DEPTH);
   localparam int LW        = AW + 1;
   localparam int LOOP_SPAN = 60;

   logic                  CLK100MHZ  = 1'b0;
   logic                  CPU_RESETN = 1'b0;
   logic                  cfg_we     = 1'b0;
   logic [AW-1:0]         cfg_addr   = '0;
   logic [TICK_W_DEF-1:0] cfg_on     = '0;
   logic [TICK_W_DEF-1:0] cfg_off    = '0;
   logic [REP_W_DEF-1:0]  cfg_rep    = '0;
   logic [LW-1:0]         seq_len    = '0;
   logic                  start      = 1'b0;
   logic                  stop       = 1'b0;
   logic                  cfg_nak;
   logic                  LED;
   logic                  busy;
   logic                  done;
   logic [AW-1:0]         step_idx;

   blink_sequencer #(.TICK_W(TICK_W_DEF), .DEPTH(DEPTH), .REP_W(REP_W_DEF)) dut (
      .CLK100MHZ  (CLK100MHZ),
      .CPU_RESETN (CPU_RESETN),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_on     (cfg_on),
      .cfg_off    (cfg_off),
      .cfg_rep    (cfg_rep),
      .cfg_nak    (cfg_nak),
      .seq_len    (seq_len),
      .start      (start),
      .stop       (stop),
      .LED        (LED),
      .busy       (busy),
      .done       (done),
      .step_idx   (step_idx)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   int cyc = 0;
   always @(posedge CLK100MHZ) cyc <= cyc + 1;

   typedef struct {
      int due;
      bit led;
      bit bsy;
      bit dn;
      bit chk_idx;
      int idx;
   } exp_t;

   exp_t  exp_q[$];
   int    nak_q[$];
   step_t tab [DEPTH];
   int    checks    = 0;
   int    errors    = 0;
   bit    mon_en    = 1'b0;
   int    last_due  = 0;
   int    run_start = -1;
   int    run_end   = 0;

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, want);
      end
   endtask

   task automatic push(input int due, input bit led, input bit bsy, input bit dn,
                       input bit chk_idx, input int idx);
      exp_t e;
      e.due = due; e.led = led; e.bsy = bsy; e.dn = dn; e.chk_idx = chk_idx; e.idx = idx;
      exp_q.push_back(e);
      last_due = due;
   endtask

   // Monitor: compare every cycle that has an expectation, plus cfg_nak always.
   always @(negedge CLK100MHZ) begin : monitor
      exp_t e;
      bit   nak_exp;
      if (mon_en) begin
         while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            check("stale_expectation", exp_q[0].due, cyc);
            void'(exp_q.pop_front());
         end
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check("LED", int'(LED), int'(e.led));
            check("busy", int'(busy), int'(e.bsy));
            check("done", int'(done), int'(e.dn));
            if (e.chk_idx) check("step_idx", int'(step_idx), e.idx);
         end
         nak_exp = 1'b0;
         while (nak_q.size() > 0 && nak_q[0] < cyc) void'(nak_q.pop_front());
         if (nak_q.size() > 0 && nak_q[0] == cyc) begin
            void'(nak_q.pop_front());
            nak_exp = 1'b1;
         end
         check("cfg_nak", int'(cfg_nak), int'(nak_exp));
      end
   end

   // Expand a run into its waveform: each step plays (rep+1) x {on+1 high, off+1 low}.
   task automatic launch(input int len_req, input int q);
      int len;
      int due;
      len = (len_req > DEPTH) ? DEPTH : len_req;
      due = q + 1;
      run_start = q;
      $display("run start cyc=%0d len=%0d", q, len);
      if (len == 0) begin
         push(due, 1'b0, 1'b0, 1'b1, 1'b0, 0);
         run_end = due;
         return;
      end
`ifdef BLINK_LOOP_EN
      do begin
`endif
         for (int s = 0; s < len; s++) begin
            for (int r = 0; r <= int'(tab[s].rep); r++) begin
               for (int k = 0; k <= int'(tab[s].on); k++)  begin push(due, 1'b1, 1'b1, 1'b0, 1'b1, s); due++; end
               for (int k = 0; k <= int'(tab[s].off); k++) begin push(due, 1'b0, 1'b1, 1'b0, 1'b1, s); due++; end
            end
         end
`ifdef BLINK_LOOP_EN
      end while (due < q + 1 + LOOP_SPAN);
      run_end = due;
`else
      push(due, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      run_end = due;
`endif
   endtask

   // One clock of stimulus; the model reacts the way the spec describes.
   task automatic drive_cycle(input bit we, input int addr, input int on, input int off,
                              input int rep, input bit st, input bit sp, input int len);
      int q;
      bit busy_m;
      @(posedge CLK100MHZ);
      #1;
      q = cyc;
      busy_m = (q > run_start) && (q < run_end);
      cfg_we   = we;
      cfg_addr = AW'(addr);
      cfg_on   = TICK_W_DEF'(on);
      cfg_off  = TICK_W_DEF'(off);
      cfg_rep  = REP_W_DEF'(rep);
      start    = st;
      stop     = sp;
      seq_len  = LW'(len);
      if (sp && busy_m) begin
         while (exp_q.size() > 0 && exp_q[$].due > q) void'(exp_q.pop_back());
         push(q + 1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
         run_end = q + 1;
         $display("stop cyc=%0d", q);
      end
      if (we) begin
         if (busy_m) begin
            nak_q.push_back(q + 1);
            $display("write dropped cyc=%0d addr=%0d", q, addr);
         end else begin
            tab[addr].on  = TICK_W_DEF'(on);
            tab[addr].off = TICK_W_DEF'(off);
            tab[addr].rep = REP_W_DEF'(rep);
            $display("write cyc=%0d addr=%0d on=%0d off=%0d rep=%0d", q, addr, on, off, rep);
         end
      end
      if (st && !sp && !busy_m) launch(len, q);
      if (last_due < q + 1) push(q + 1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic idle(input int n);
      repeat (n) drive_cycle(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic finish_run();
      int g;
      g = 0;
`ifdef BLINK_LOOP_EN
      idle($urandom_range(1, 30));
      drive_cycle(0, 0, 0, 0, 0, 0, 1, 0);
`endif
      while (cyc < run_end && g < 2000) begin
         idle(1);
         g++;
      end
      if (g >= 2000) check("run_timeout", g, 0);
      idle(2);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) tab[i] = '0;
      repeat (3) @(posedge CLK100MHZ);
      @(negedge CLK100MHZ);
      check("reset_LED", int'(LED), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_cfg_nak", int'(cfg_nak), 0);
      check("reset_step_idx", int'(step_idx), 0);
      @(posedge CLK100MHZ);
      #1;
      CPU_RESETN = 1'b1;
      mon_en = 1'b1;
      idle(20);

      // Single step {2,1,0}.
      drive_cycle(1, 0, 2, 1, 0, 0, 0, 0);
      drive_cycle(0, 0, 0, 0, 0, 1, 0, 1);
      finish_run();

      // Two steps {1,1,1},{0,2,0}.
      drive_cycle(1, 0, 1, 1, 1, 0, 0, 0);
      drive_cycle(1, 1, 0, 2, 0, 0, 0, 0);
      drive_cycle(0, 0, 0, 0, 0, 1, 0, 2);
      finish_run();

      // Write and start while busy are refused; rerun shows the old entry.
      drive_cycle(0, 0, 0, 0, 0, 1, 0, 1);
      idle(2);
      drive_cycle(1, 0, 5, 5, 3, 0, 0, 0);
      drive_cycle(0, 0, 0, 0, 0, 1, 0, 2);
      finish_run();
      drive_cycle(0, 0, 0, 0, 0, 1, 0, 1);
      finish_run();

      // Stop during ON, then stop+start together while idle.
      drive_cycle(1, 0, 9, 3, 0, 0, 0, 0);
      drive_cycle(0, 0, 0, 0, 0, 1, 0, 1);
      idle(3);
      drive_cycle(0, 0, 0, 0, 0, 0, 1, 0);
      idle(3);
      drive_cycle(0, 0, 0, 0, 0, 1, 1, 1);
      idle(5);

      // seq_len=0, write on the start edge, oversize seq_len.
      drive_cycle(0, 0, 0, 0, 0, 1, 0, 0);
      idle(3);
      drive_cycle(1, 0, 1, 0, 0, 1, 0, 1);
      finish_run();
      drive_cycle(0, 0, 0, 0, 0, 1, 0, 15);
      finish_run();

      // Randomised runs with random mid-run writes, starts and stops.
      for (int it = 0; it < 25; it++) begin
         int k;
         for (int a = 0; a < DEPTH; a++) begin
            if ($urandom_range(0, 1) == 1)
               drive_cycle(1, a, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 2), 0, 0, 0);
         end
         drive_cycle(0, 0, 0, 0, 0, 1, 0, $urandom_range(0, 15));
         k = 0;
         while (cyc < run_end && k < 2000) begin
            bit sp;
            sp = ($urandom_range(0, 99) < 3);
`ifdef BLINK_LOOP_EN
            if (k == 40) sp = 1'b1;
`endif
            drive_cycle($urandom_range(0, 99) < 10, $urandom_range(0, DEPTH - 1), $urandom_range(0, 7),
                        $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 99) < 5, sp,
                        $urandom_range(1, 8));
            k++;
         end
         if (k >= 2000) check("random_run_timeout", k, 0);
         idle(2);
      end

      idle(3);
      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/blink_sequencer.md
Name: blink_sequencer

Overview:
Programmable LED pattern controller for the board-level blink logic. It holds a small table of steps, each step being on-count, off-count and repeat. It drives one on/off timer through those steps in order and produces a single LED output plus busy/done status. It replaces hard-wired divider constants with a sequence loaded at run time from the control logic.

Parameters:
TICK_W, 28, width of the on/off count fields; matches the 28-bit counters used on the 100 MHz board clock.
DEPTH, 8, number of step-table entries; must be a power of two, minimum 2.
REP_W, 4, width of the per-step repeat field.

Ports:
CLK100MHZ  input  1  board clock, 100 MHz; all logic on its rising edge.
CPU_RESETN  input  1  asynchronous active-low reset.
cfg_we  input  1  step-table write strobe.
cfg_addr  input  $clog2(DEPTH)  step index to write.
cfg_on  input  TICK_W  on-count; the ON phase lasts cfg_on+1 cycles.
cfg_off  input  TICK_W  off-count; the OFF phase lasts cfg_off+1 cycles.
cfg_rep  input  REP_W  repeat count; the step runs cfg_rep+1 times.
cfg_nak  output  1  one-cycle pulse when a write is dropped.
seq_len  input  $clog2(DEPTH)+1  number of steps to run (0..DEPTH); sampled on an accepted start.
start  input  1  single-cycle start request.
stop  input  1  abort request.
LED  output  1  pattern output.
busy  output  1  high while a sequence is running.
done  output  1  one-cycle pulse when a sequence completes normally.
step_idx  output  $clog2(DEPTH)  index of the step currently running.

Behaviour:
- Reset (CPU_RESETN=0, asynchronous): table entries = 0; LED, busy, done and cfg_nak = 0; step_idx = 0; state = IDLE. Deassertion is synchronised externally.
- States: IDLE, ON, OFF.
- Table writes:
  - Accepted only in IDLE; the entry is updated on that edge.
  - cfg_we while busy: write dropped, cfg_nak=1 for the next cycle.
  - A write to the same cycle as an accepted start is accepted, and the sequence uses the new value.
- start (sampled in IDLE):
  - With seq_len in 1..DEPTH: len is latched, step_idx=0, the repeat counter is loaded, the tick counter is cleared, and the state goes to ON. busy=1 and LED=1 on the next cycle.
  - With seq_len=0: no run; done pulses the next cycle and busy stays 0.
  - With seq_len>DEPTH: clamped to DEPTH.
  - start while busy: ignored.
- ON: LED=1. The tick counter counts 0..on. When count==on, the counter clears and the state goes to OFF. The ON phase is exactly on+1 cycles.
- OFF: LED=0 for exactly off+1 cycles. At the end of the phase:
  - If repeats remain: decrement the repeat counter and go to ON (same step).
  - Else if step_idx < len-1: step_idx+1, reload the repeat counter from the new entry, go to ON.
  - Else: go to IDLE, busy=0, and done=1 for one cycle, coincident with busy falling.
- Count fields are read from the table live at each phase start; the table cannot change while busy, so the values are stable.
- stop: honoured in any state.
  - Next cycle: state=IDLE, LED=0, busy=0, step_idx=0, no done pulse.
  - stop has priority over start in the same cycle.
  - stop in IDLE is a no-op.
- Counters are unsigned, TICK_W wide, and never wrap: the compare terminates each phase before overflow.
- Reset mid-run: immediate return to reset values; table contents are lost.

Optional Feature:
Macro BLINK_LOOP_EN.
- Defined: after the last step's final OFF phase, the sequencer wraps to step 0 and continues indefinitely. done never pulses for len>=1; only stop or reset ends the run.
- Undefined: single pass with a done pulse, as described above.
- seq_len=0 behaviour is identical in both builds.

Decomposition:
- Package blink_pkg:
  - typedef step_t {on, off, rep}.
  - State enum.
  - Constants TICK_W_DEF=28, DEPTH_DEF=8, REP_W_DEF=4.
  - Convenience constants MS_1=99_999 and S_1=99_999_999 (counts for 1 ms and 1 s).
- Sub-module onoff_timer:
  - Holds the tick counter and phase-end compare.
  - Inputs: load, limit. Output: expire.
  - The sequencer FSM instantiates one copy.

Test Plan:
- Reset then idle: all outputs 0; cfg_nak, done and LED remain 0 over 20 cycles.
- Entry0 = {on=2, off=1, rep=0}, seq_len=1, start:
  - LED high for 3 cycles, low for 2.
  - done pulses on the cycle busy falls; total busy = 5 cycles.
- Entries {1,1,1} and {0,2,0}, seq_len=2:
  - LED pattern 11 00 11 00 1 000.
  - step_idx shows 0 then 1; done pulses once.
- Write during run: cfg_we while busy → cfg_nak pulse, entry unchanged (read back via a rerun); second start while busy is ignored.
- stop in the middle of an ON phase: LED=0 and busy=0 the next cycle, no done pulse. stop+start in the same cycle while IDLE: no run starts.
- seq_len=0 start → done pulse only, busy stays 0. With BLINK_LOOP_EN, the seq_len=1 {0,0,0} run toggles LED 1,0,1,0… until stop.
